dac_sample_pacer: RTL

Upstream pacing stage for the DAC SPI serializer. It accepts signed 12-bit samples from a producer at any burst rate and buffers them in a small FIFO. It releases them as single-cycle Avalon-ST valid pulses at a programmed sample period in `sclk` cycles, clamped so the serializer always has finished its 32-bit frame before the next sample arrives. On underflow it repeats the last sample and flags it on the error lane.

---
 rtl/dac_sample_pacer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer
//   Buffers signed producer samples in a small first-word-fall-through FIFO
//   and releases them to the DAC SPI serializer as single-cycle Avalon-ST
//   valid pulses, one every max(period, MIN_PERIOD) sclk cycles. When the
//   FIFO runs dry during RUN, the last emitted sample is repeated and
//   flagged with error code 2'b01.
//
// Ports
//   sclk              clock, rising edge
//   reset             synchronous, active-high
//   en                run enable (also enables the serializer)
//   period            requested sample period in sclk cycles
//   in_data/in_valid  producer sample and valid
//   in_ready          FIFO can accept (not full and not in reset)
//   ast_source_data   sample to serializer (held between pulses)
//   ast_source_valid  one-cycle pulse per emitted sample
//   ast_source_error  2'b00 normal, 2'b01 underflow repeat
//   fifo_level        FIFO occupancy, 0..2^FIFO_AW
//   underflow_count   saturating count of underflow repeats
module dac_sample_pacer #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned MIN_PERIOD   = 36,
  parameter int unsigned PRIME_LEVEL  = 8
) (
  input  logic                    sclk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   ast_source_data,
  output logic                    ast_source_valid,
  output logic [1:0]              ast_source_error,
  output logic [FIFO_AW:0]        fifo_level,
  output logic [15:0]             underflow_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]        DEPTH_LVL  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]        PRIME_LVL  = (FIFO_AW+1)'(PRIME_LEVEL);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P      = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P_M1   = PERIOD_WIDTH'(MIN_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr;
  logic [FIFO_AW-1:0]      rd_ptr;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] eff_m1;
  logic [DATA_WIDTH-1:0]   last;
  logic [DATA_WIDTH-1:0]   head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    tick;
  logic                    pop;

  assign full     = (fifo_level == DEPTH_LVL);
  assign empty    = (fifo_level == '0);
  assign in_ready = ~full & ~reset;
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];
  // en low in the tick cycle suppresses the tick entirely (no pulse, no pop).
  assign tick     = (state == RUN) & en & (cnt == '0);
  assign pop      = tick & ~empty;

  always_comb begin
    eff_m1 = period - 1'b1;
    if (period < MIN_P) eff_m1 = MIN_P_M1;
  end

  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_level       <= '0;
      last             <= '0;
      ast_source_data  <= '0;
      ast_source_valid <= 1'b0;
      ast_source_error <= 2'b00;
      underflow_count  <= '0;
    end else begin
      ast_source_valid <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push && pop) fifo_level <= fifo_level - 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) state <= PRIME;
        end
        PRIME: begin
          if (!en) begin
            state <= IDLE;
          end else if (fifo_level >= PRIME_LVL) begin
            state <= RUN;
            cnt   <= eff_m1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            cnt              <= eff_m1;
            ast_source_valid <= 1'b1;
            if (!empty) begin
              ast_source_data  <= head;
              ast_source_error <= 2'b00;
              last             <= head;
            end else begin
              ast_source_data  <= last;
              ast_source_error <= 2'b01;
              if (underflow_count != '1) underflow_count <= underflow_count + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
